// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types and helpers for the sequential Booth multiplier.
//                - state_t   : controller states (IDLE, RUN, DONE)
//                - cnt_width : step-counter width for a given operand width,
//                              i.e. $clog2(WIDTH+2)
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must hold values 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
//  Module      : booth_step
//  Description : One combinational radix-2 Booth step. Selects add / subtract
//                / hold of the sign-extended multiplicand based on {X[0], E},
//                then arithmetic-shifts {A, X, E} right by one bit.
//  Ports       : i_a [WIDTH+1:0]  accumulator A
//                i_x [WIDTH:0]    multiplier shift register X
//                i_e              previous multiplier bit E
//                i_y [WIDTH:0]    multiplicand Y
//                o_a, o_x, o_e    next A, X, E
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH+1:0] i_a,
  input  logic [WIDTH:0]   i_x,
  input  logic             i_e,
  input  logic [WIDTH:0]   i_y,
  output logic [WIDTH+1:0] o_a,
  output logic [WIDTH:0]   o_x,
  output logic             o_e
);

  logic [WIDTH+1:0] w_y_ext;
  logic [WIDTH+1:0] w_sum;

  assign w_y_ext = {i_y[WIDTH], i_y};

  always_comb begin
    w_sum = i_a;
    case ({i_x[0], i_e})
      2'b01:   w_sum = i_a + w_y_ext;
      2'b10:   w_sum = i_a - w_y_ext;
      default: w_sum = i_a;
    endcase
  end

  // Arithmetic shift of the concatenation {A, X, E}: A's MSB is replicated,
  // A's LSB drops into X, X's LSB becomes the new E.
  assign o_a = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
  assign o_x = {w_sum[0], i_x[WIDTH:1]};
  assign o_e = i_x[0];

endmodule
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult_seq
//  Description : Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH,
//                signed or unsigned per transaction, valid/ready on both sides.
//                Operands are widened by one bit so unsigned values run through
//                the same signed Booth recurrence; WIDTH+1 steps are taken.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid / in_ready, in_x, in_y, in_signed  - operand side
//                out_valid / out_ready, out_product          - result side
//                busy                                        - RUN or DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy
);

  localparam int             CNT_W      = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH+1:0]   r_a;
  logic [WIDTH:0]     r_x;
  logic [WIDTH:0]     r_y;
  logic               r_e;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH+1:0]   w_a_next;
  logic [WIDTH:0]     w_x_next;
  logic               w_e_next;
  logic [2*WIDTH+2:0] w_full;
  logic [2:0]         w_unused_hi;
  logic               w_accept;
  logic               w_last;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a (r_a),
    .i_x (r_x),
    .i_e (r_e),
    .i_y (r_y),
    .o_a (w_a_next),
    .o_x (w_x_next),
    .o_e (w_e_next)
  );

  // The exact product always fits in the low 2*WIDTH bits; the top bits are
  // only sign replicas of the widened operands.
  assign w_full      = {w_a_next, w_x_next};
  assign w_unused_hi = w_full[2*WIDTH+2:2*WIDTH];

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_state == RUN) && (r_cnt == c_last_cnt);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == c_last_cnt) w_state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_e       <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_y   <= {in_signed & in_y[WIDTH-1], in_y};
      r_x   <= {in_signed & in_x[WIDTH-1], in_x};
      r_a   <= '0;
      r_e   <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= w_a_next;
      r_x   <= w_x_next;
      r_e   <= w_e_next;
      r_cnt <= r_cnt + CNT_W'(1);
      // Result is captured once, on the final step, so it stays stable
      // through DONE and afterwards until the next completion.
      if (w_last) r_product <= w_full[2*WIDTH-1:0];
    end
  end

  assign out_product = r_product;

endmodule
`default_nettype wire

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier with its own controller and a valid/ready handshake on both sides. It is the successor to the fixed 5-bit Booth datapath-plus-controller pair. It takes two WIDTH-bit operands per transaction, signed or unsigned as selected per transaction, and returns the exact 2·WIDTH-bit product. It sits between an operand producer and a result consumer, and either side may stall.

## Interface
- WIDTH, default 5: operand width; legal range 2..32.
- clk  in  1: single clock; all state changes on the rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- in_valid  in  1: operands present.
- in_ready  out  1: block can accept operands; high only in IDLE.
- in_x  in  WIDTH: multiplier operand (shifted register X).
- in_y  in  WIDTH: multiplicand operand (register Y).
- in_signed  in  1: 1 = two's-complement operands, 0 = unsigned; sampled at accept.
- out_valid  out  1: product available; high only in DONE.
- out_ready  in  1: consumer takes the product.
- out_product  out  2·WIDTH: product, held stable while out_valid=1.
- busy  out  1: high in RUN or DONE.

## Operation
- Accept occurs on a rising edge with in_valid & in_ready.
- At accept, load the following and go to RUN:
  - Y ← in_y extended to WIDTH+1 bits (sign-extended if in_signed, else zero-extended);
  - X ← in_x extended the same way;
  - A ← 0, WIDTH+2 bits;
  - E ← 0;
  - cnt ← 0.
- Each RUN edge performs one Booth step on the bit pair {X[0], E}:
  - 01: A ← A + sext(Y);
  - 10: A ← A − sext(Y);
  - 00 or 11: A unchanged.
  - Then arithmetic-shift {A, X, E} right by one (A MSB replicated), and cnt ← cnt + 1.
- After WIDTH+1 steps (cnt reaches WIDTH), go to DONE.
- In DONE, out_product = low 2·WIDTH bits of {A, X} after the last step. This is exact for every signed or unsigned operand pair, including min×min and max×max.
- DONE → IDLE on a rising edge with out_ready=1. The product register keeps its value until the next DONE.
- State machine:
  - IDLE → RUN on accept;
  - RUN → DONE when cnt = WIDTH;
  - DONE → IDLE on out_ready.
- No early termination, no abort input.
- in_* are ignored outside IDLE. Operands changing mid-RUN have no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_product=0; state=IDLE, A, X, Y, E, cnt all zero.
- Latency: out_valid rises exactly WIDTH+1 edges after the accept edge (6 for WIDTH=5).
- Throughput: one transaction per WIDTH+3 cycles with out_ready held high.
  - Accept edge, WIDTH+1 RUN edges, DONE edge, IDLE.
  - in_ready is asserted the cycle after the DONE→IDLE edge; no back-to-back accept in the DONE cycle.
- Backpressure: out_valid and out_product hold indefinitely while out_ready=0; in_ready stays 0.
- out_ready=1 outside DONE: no effect.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and never presented.
- Reset deasserted with in_valid=1: the first accept happens on the first edge after deassertion.

## Structure
- Shared package booth_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam CNT_W = $clog2(WIDTH+2).
- Sub-module booth_step (combinational), parametrised by WIDTH.
  - Inputs: A, X, E, Y.
  - Performs the add/sub selection and arithmetic shift; returns the next A, X, E.
- Top level holds registers, counter, FSM and handshake logic.

## Test plan
All scenarios use WIDTH=5.
- Signed 10×13: in_x=5'b01010, in_y=5'b01101, in_signed=1 → out_product=10'd130, out_valid exactly 6 edges after accept.
- Signed corners:
  - −16×−16 → 10'd256;
  - −16×15 → 10'h310 (−240).
- Unsigned 31×31, in_signed=0 → 10'd961. The same bit pattern with in_signed=1 (−1×−1) → 10'd1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid=1, product unchanged, in_ready=0 throughout. Release → in_ready=1 next cycle, and a new accept works.
- Reset mid-RUN: pulse rst_n low at step 3 → out_valid=0, in_ready=1, out_product=0 immediately. A following 7×3 signed transaction → 10'd21.
- Randomised back-to-back stream of 200 transactions, mixed modes, random out_ready → every product matches the reference model; no lost or duplicated results.
